// File: rtl/dma_stall_tracer_if.sv
// Bus bundle for dma_stall_tracer: openMSP430 peripheral port plus DMA master port.
// master = bus/system side, slave = the tracer block.
interface dma_stall_tracer_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic [14:0] dma_addr;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic [15:0] dma_dout;
    logic        dma_ready;

    modport master (
        output per_addr, per_din, per_en, per_we, dma_ready,
        input  per_dout, dma_addr, dma_en, dma_we, dma_dout
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we, dma_ready,
        output per_dout, dma_addr, dma_en, dma_we, dma_dout
    );
endinterface

// File: rtl/dma_stall_tracer.sv
// DMA contention probe: after a programmed delay, issues a DMA burst and
// records one stall bit (~dma_ready) per cycle into a readable trace buffer.
module dma_stall_tracer #(
    parameter int unsigned CAPTURE_LENGTH = 2048,
    parameter logic [14:0] BASE_ADDR      = 15'h0070,
    parameter int unsigned DEC_WD         = 4
) (
    input  logic              mclk,
    input  logic              puc_rst,
    dma_stall_tracer_if.slave bus
);
    localparam int unsigned NW = CAPTURE_LENGTH / 16;
    localparam int unsigned IW = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
    localparam int unsigned TW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(CAPTURE_LENGTH - 1);
    localparam logic [TW-1:0] LAST_TIDX = TW'(NW - 1);
    localparam logic [15:0]   LEN_RST   = 16'(CAPTURE_LENGTH);

    localparam logic [DEC_WD-2:0] R_ADDR   = (DEC_WD-1)'(0);
    localparam logic [DEC_WD-2:0] R_DELAY  = (DEC_WD-1)'(1);
    localparam logic [DEC_WD-2:0] R_CTRL   = (DEC_WD-1)'(2);
    localparam logic [DEC_WD-2:0] R_LEN    = (DEC_WD-1)'(3);
    localparam logic [DEC_WD-2:0] R_TIDX   = (DEC_WD-1)'(4);
    localparam logic [DEC_WD-2:0] R_TDATA  = (DEC_WD-1)'(5);
    localparam logic [DEC_WD-2:0] R_STATUS = (DEC_WD-1)'(6);
    localparam logic [DEC_WD-2:0] R_SCNT   = (DEC_WD-1)'(7);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_CAPTURE} state_t;

    state_t                  state_q;
    logic [15:0]             addr_q, delay_q, len_q, wdata_q;
    logic [15:0]             scnt_q, cnt_q, tdata_q, dma_dout_q;
    logic [1:0]              ctrl_q, dma_we_q;
    logic [TW-1:0]           tidx_q;
    logic [IW-1:0]           idx_q, lenm1_q, lenm1_d;
    logic [CAPTURE_LENGTH-1:0] trace_q;
    logic [14:0]             dma_addr_q;
    logic                    done_q, dma_en_q;

    logic [DEC_WD-2:0] reg_idx;
    logic [15:0]       scnt_d, rdata_d;
    logic              sel, rd, wr, busy, arm, abort, stall;

    assign sel     = bus.per_en &&
                     (bus.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign wr      = sel && (bus.per_we != 2'b00);
    assign rd      = sel && (bus.per_we == 2'b00);
    assign reg_idx = bus.per_addr[DEC_WD-2:0];
    assign busy    = (state_q != S_IDLE);
    assign abort   = wr && (reg_idx == R_DELAY) && (bus.per_din == 16'hFFFF);
    assign arm     = wr && (reg_idx == R_DELAY) && !busy &&
                     (bus.per_din != 16'hFFFF);
    assign stall   = ~bus.dma_ready;
    assign scnt_d  = (scnt_q == 16'hFFFF || !stall) ? scnt_q : scnt_q + 16'd1;

    // Effective burst length minus one, clamped to the buffer depth.
    always_comb begin
        lenm1_d = '0;
        if (len_q == 16'd0)
            lenm1_d = '0;
        else if (32'(len_q) > CAPTURE_LENGTH)
            lenm1_d = LAST_IDX;
        else
            lenm1_d = IW'(len_q - 16'd1);
    end

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            unique case (reg_idx)
                R_ADDR:   rdata_d = addr_q;
                R_DELAY:  rdata_d = delay_q;
                R_CTRL:   rdata_d = {14'd0, ctrl_q};
                R_LEN:    rdata_d = len_q;
                R_TIDX:   rdata_d = 16'(tidx_q);
                R_TDATA:  rdata_d = tdata_q;
                R_STATUS: rdata_d = {13'd0, done_q, state_q == S_CAPTURE,
                                     state_q == S_DELAY};
                R_SCNT:   rdata_d = scnt_q;
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            delay_q    <= 16'hFFFF;
            ctrl_q     <= '0;
            len_q      <= LEN_RST;
            wdata_q    <= '0;
            tidx_q     <= '0;
            tdata_q    <= '0;
            scnt_q     <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            lenm1_q    <= '0;
            trace_q    <= '0;
            done_q     <= 1'b0;
            dma_en_q   <= 1'b0;
            dma_we_q   <= 2'b00;
            dma_addr_q <= '0;
            dma_dout_q <= '0;
        end else begin
            tdata_q <= trace_q[{tidx_q, 4'b0000} +: 16];

            if (wr && !busy && reg_idx == R_ADDR)  addr_q  <= bus.per_din;
            if (wr && !busy && reg_idx == R_CTRL)  ctrl_q  <= bus.per_din[1:0];
            if (wr && !busy && reg_idx == R_LEN)   len_q   <= bus.per_din;
            if (wr && !busy && reg_idx == R_TDATA) wdata_q <= bus.per_din;
            if (wr && reg_idx == R_STATUS && bus.per_din[2]) done_q <= 1'b0;

            if (wr && reg_idx == R_TIDX)
                tidx_q <= bus.per_din[TW-1:0];
            else if (rd && reg_idx == R_TDATA)
                tidx_q <= (tidx_q == LAST_TIDX) ? '0 : tidx_q + 1'b1;

            // Abort wins over any in-flight sample; partial trace is kept.
            if (abort) begin
                delay_q  <= 16'hFFFF;
                dma_en_q <= 1'b0;
                dma_we_q <= 2'b00;
                state_q  <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (arm) begin
                            delay_q <= bus.per_din;
                            cnt_q   <= bus.per_din;
                            trace_q <= '0;
                            scnt_q  <= '0;
                            done_q  <= 1'b0;
                            lenm1_q <= lenm1_d;
                            state_q <= S_DELAY;
                        end
                    end
                    S_DELAY: begin
                        if (cnt_q != 16'd0) begin
                            cnt_q <= cnt_q - 16'd1;
                        end else begin
                            dma_en_q   <= 1'b1;
                            dma_addr_q <= addr_q[15:1];
                            dma_we_q   <= ctrl_q[0] ? 2'b11 : 2'b00;
                            dma_dout_q <= wdata_q;
                            idx_q      <= '0;
                            state_q    <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        trace_q[idx_q] <= stall;
                        scnt_q         <= scnt_d;
                        idx_q          <= idx_q + 1'b1;
                        if (ctrl_q[1] && bus.dma_ready)
                            dma_addr_q <= dma_addr_q + 15'd1;
                        if (idx_q == lenm1_q) begin
                            dma_en_q <= 1'b0;
                            dma_we_q <= 2'b00;
                            done_q   <= 1'b1;
                            state_q  <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.per_dout = rdata_d;
    assign bus.dma_en   = dma_en_q;
    assign bus.dma_we   = dma_we_q;
    assign bus.dma_addr = dma_addr_q;
    assign bus.dma_dout = dma_dout_q;
endmodule

// File: tb/tb_dma_stall_tracer.sv
// Testbench for dma_stall_tracer: table-driven bursts, randomized bursts
// against a sample-level reference model, and abort/reset sequences.
module tb_dma_stall_tracer;
    localparam int CL = 2048;
    localparam logic [13:0] RB = 14'h38;
    localparam logic [2:0] R_ADDR = 3'd0, R_DELAY = 3'd1, R_CTRL = 3'd2;
    localparam logic [2:0] R_LEN = 3'd3, R_TIDX = 3'd4, R_TDATA = 3'd5;
    localparam logic [2:0] R_STATUS = 3'd6, R_SCNT = 3'd7;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] delay;
        logic [15:0] len;
        logic [15:0] wdata;
        logic [15:0] pat;
        logic [1:0]  ctrl;
        int          exp_n;
        logic [15:0] exp_t0;
        logic [15:0] exp_scnt;
    } vec_t;

    logic mclk = 1'b0;
    logic puc_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit [CL-1:0] exp_trace;
    bit          rdy [CL];
    vec_t        tbl [6];

    dma_stall_tracer_if bus();

    dma_stall_tracer #(.CAPTURE_LENGTH(CL)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus     (bus)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] r, input logic [15:0] d);
        bus.per_en   = 1'b1;
        bus.per_we   = 2'b11;
        bus.per_addr = RB + 14'(r);
        bus.per_din  = d;
        step();
        bus.per_en = 1'b0;
        bus.per_we = 2'b00;
    endtask

    task automatic rd(input logic [2:0] r, output logic [15:0] d);
        bus.per_en   = 1'b1;
        bus.per_we   = 2'b00;
        bus.per_addr = RB + 14'(r);
        #1 d = bus.per_dout;
        step();
        bus.per_en = 1'b0;
    endtask

    task automatic rdchk(input logic [2:0] r, input logic [15:0] exp,
                         input string nm);
        logic [15:0] v;
        rd(r, v);
        chk(nm, 32'(v), 32'(exp));
    endtask

    task automatic wait_en(input int limit, input string nm);
        int w;
        w = 0;
        while (!bus.dma_en && w < limit) begin
            step();
            w++;
        end
        chk(nm, 32'(bus.dma_en), 32'd1);
    endtask

    // Program, arm, drive and read back one burst; the model is the list of
    // ready bits per sample, from which trace, count and addresses follow.
    task automatic run_burst(input logic [15:0] a, input logic [15:0] dly,
                             input logic [15:0] ln, input logic [15:0] wd,
                             input logic [15:0] pat, input logic [1:0] ct,
                             input bit rnd, output int n_seen,
                             output logic [15:0] t0, output logic [15:0] sc);
        int leff, w, scnt, nw;
        logic [14:0] ea;
        logic [15:0] v;
        leff = (ln == 16'd0) ? 1 : ((int'(ln) > CL) ? CL : int'(ln));
        exp_trace = '0;
        scnt = 0;
        for (int k = 0; k < CL; k++) begin
            if (k >= leff) rdy[k] = 1'b1;
            else if (rnd) rdy[k] = ($urandom_range(3) != 0);
            else rdy[k] = (k < 16) ? pat[k] : 1'b1;
            if (k < leff && !rdy[k]) begin
                exp_trace[k] = 1'b1;
                scnt++;
            end
        end
        wr(R_ADDR, a);
        wr(R_CTRL, {14'd0, ct});
        wr(R_LEN, ln);
        wr(R_TDATA, wd);
        wr(R_DELAY, dly);
        w = 0;
        while (!bus.dma_en && w < int'(dly) + 20) begin
            step();
            w++;
        end
        chk("en_delay", 32'(w), 32'(dly) + 32'd1);
        chk("dma_we", 32'(bus.dma_we), 32'(ct[0] ? 2'b11 : 2'b00));
        chk("dma_dout", 32'(bus.dma_dout), 32'(wd));
        ea = a[15:1];
        n_seen = 0;
        while (bus.dma_en && n_seen < leff + 4) begin
            bus.dma_ready = (n_seen < leff) ? rdy[n_seen] : 1'b1;
            chk("dma_addr", 32'(bus.dma_addr), 32'(ea));
            if (ct[1] && bus.dma_ready) ea = ea + 15'd1;
            step();
            n_seen++;
        end
        bus.dma_ready = 1'b1;
        chk("burst_len", 32'(n_seen), 32'(leff));
        rdchk(R_STATUS, 16'h0004, "status_done");
        rd(R_SCNT, sc);
        chk("scnt", 32'(sc), 32'(scnt));
        wr(R_TIDX, 16'd0);
        step();
        nw = (leff + 15) / 16 + 1;
        if (nw > CL / 16) nw = CL / 16;
        t0 = '0;
        for (int i = 0; i < nw; i++) begin
            rd(R_TDATA, v);
            if (i == 0) t0 = v;
            chk($sformatf("tdata%0d", i), 32'(v), 32'(exp_trace[16*i +: 16]));
            step();
        end
    endtask

    initial begin
        int n;
        logic [15:0] t0, sc, v;

        tbl[0] = '{16'h0200, 16'd3, 16'd4,  16'h0000, 16'hFFFF, 2'd0, 4, 16'h0000, 16'd0};
        tbl[1] = '{16'h0200, 16'd5, 16'd8,  16'h0000, 16'hFFF9, 2'd0, 8, 16'h0006, 16'd2};
        tbl[2] = '{16'h0200, 16'd2, 16'd4,  16'hA5A5, 16'hFFFD, 2'd3, 4, 16'h0002, 16'd1};
        tbl[3] = '{16'h0300, 16'd0, 16'd0,  16'h1111, 16'hFFFE, 2'd0, 1, 16'h0001, 16'd1};
        tbl[4] = '{16'hFFFE, 16'd1, 16'd3,  16'h0000, 16'hFFFF, 2'd2, 3, 16'h0000, 16'd0};
        tbl[5] = '{16'h0040, 16'd4, 16'd16, 16'h5A5A, 16'h00FF, 2'd1, 16, 16'hFF00, 16'd8};

        bus.per_addr  = '0;
        bus.per_din   = '0;
        bus.per_en    = 1'b0;
        bus.per_we    = 2'b00;
        bus.dma_ready = 1'b1;
        #12;
        chk("rst_dma_en", 32'(bus.dma_en), 32'd0);
        puc_rst = 1'b0;
        step();

        chk("rst_dma_addr", 32'(bus.dma_addr), 32'd0);
        chk("rst_dma_we", 32'(bus.dma_we), 32'd0);
        chk("rst_dma_dout", 32'(bus.dma_dout), 32'd0);
        rdchk(R_ADDR, 16'h0000, "rst_addr");
        rdchk(R_DELAY, 16'hFFFF, "rst_delay");
        rdchk(R_CTRL, 16'h0000, "rst_ctrl");
        rdchk(R_LEN, 16'd2048, "rst_len");
        rdchk(R_TIDX, 16'h0000, "rst_tidx");
        rdchk(R_TDATA, 16'h0000, "rst_tdata");
        rdchk(R_STATUS, 16'h0000, "rst_status");
        rdchk(R_SCNT, 16'h0000, "rst_scnt");

        bus.per_en = 1'b1;
        bus.per_addr = 14'h0040;
        #1 chk("unsel_dout", 32'(bus.per_dout), 32'd0);
        bus.per_en = 1'b0;
        step();

        wr(R_DELAY, 16'hFFFF);
        step(3);
        chk("ffff_no_arm", 32'(bus.dma_en), 32'd0);
        rdchk(R_STATUS, 16'h0000, "ffff_status");

        for (int i = 0; i < 6; i++) begin
            run_burst(tbl[i].addr, tbl[i].delay, tbl[i].len, tbl[i].wdata,
                      tbl[i].pat, tbl[i].ctrl, 1'b0, n, t0, sc);
            chk($sformatf("tbl%0d_n", i), 32'(n), 32'(tbl[i].exp_n));
            chk($sformatf("tbl%0d_t0", i), 32'(t0), 32'(tbl[i].exp_t0));
            chk($sformatf("tbl%0d_scnt", i), 32'(sc), 32'(tbl[i].exp_scnt));
        end

        wr(R_STATUS, 16'h0004);
        rdchk(R_STATUS, 16'h0000, "w1c_done");

        for (int i = 0; i < 10; i++) begin
            run_burst(16'($urandom), 16'($urandom_range(15)),
                      16'($urandom_range(40)), 16'($urandom), 16'h0,
                      2'($urandom_range(3)), 1'b1, n, t0, sc);
        end

        run_burst(16'h0100, 16'd1, 16'd5000, 16'h0, 16'h0, 2'd2, 1'b1, n, t0, sc);
        chk("len_clamp", 32'(n), 32'd2048);
        rdchk(R_TIDX, 16'h0000, "tidx_wrap");

        wr(R_ADDR, 16'h0400);
        wr(R_LEN, 16'd100);
        wr(R_CTRL, 16'h0000);
        wr(R_DELAY, 16'd6);
        rdchk(R_STATUS, 16'h0001, "status_delay");
        wait_en(30, "abort_en_up");
        step(2);
        wr(R_ADDR, 16'h1234);
        rdchk(R_STATUS, 16'h0002, "status_capture");
        wr(R_DELAY, 16'hFFFF);
        chk("abort_en", 32'(bus.dma_en), 32'd0);
        rdchk(R_STATUS, 16'h0000, "abort_status");
        rdchk(R_ADDR, 16'h0400, "busy_addr_ignored");
        rdchk(R_DELAY, 16'hFFFF, "abort_delay");
        rdchk(R_SCNT, 16'h0000, "abort_scnt");

        wr(R_LEN, 16'd50);
        wr(R_DELAY, 16'd1);
        wait_en(20, "rst_burst_up");
        bus.dma_ready = 1'b0;
        step(3);
        puc_rst = 1'b1;
        #1 chk("rst_async_en", 32'(bus.dma_en), 32'd0);
        #3 puc_rst = 1'b0;
        bus.dma_ready = 1'b1;
        step();
        rdchk(R_DELAY, 16'hFFFF, "post_rst_delay");
        rdchk(R_SCNT, 16'h0000, "post_rst_scnt");
        rdchk(R_LEN, 16'd2048, "post_rst_len");
        rdchk(R_STATUS, 16'h0000, "post_rst_status");
        wr(R_TIDX, 16'd0);
        step();
        rd(R_TDATA, v);
        chk("post_rst_tdata", 32'(v), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
